// File: rtl/piece_step_ctrl.sv
// Falling-block game sequencer: owns the falling-piece and settled-block bitmaps,
// arbitrates gravity and button moves, locks pieces, clears full rows, spawns and detects game over.
module piece_step_ctrl #(
  parameter int unsigned          COLS        = 12,
  parameter int unsigned          ROWS        = 12,
  parameter int unsigned          DROP_TICKS  = 25_000_000,
  parameter logic [ROWS*COLS-1:0] SPAWN_PIECE = 144'h20070,
  parameter logic [ROWS*COLS-1:0] INIT_BG     = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   left,
  input  logic                   right,
  input  logic                   down,
  input  logic                   up,
  output logic [ROWS*COLS-1:0]   moving_squares,
  output logic [ROWS*COLS-1:0]   background,
  output logic [15:0]            lines_cleared,
  output logic                   lock_pulse,
  output logic                   game_over
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = $clog2(DROP_TICKS);

  function automatic logic [N-1:0] col_mask(input int unsigned c);
    logic [N-1:0] m;
    m = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      m = m | (N'(1) << (r * COLS + c));
    end
    return m;
  endfunction

  localparam logic [N-1:0] ONES    = '1;
  localparam logic [N-1:0] COL0    = col_mask(0);
  localparam logic [N-1:0] COLL    = col_mask(COLS - 1);
  localparam logic [N-1:0] LASTROW = ONES << ((ROWS - 1) * COLS);

  typedef enum logic [2:0] {S_SPAWN, S_RUN, S_DROP, S_LOCK, S_CLEAR, S_OVER} state_t;

  state_t          state_q, state_n;
  logic [N-1:0]    mv_q, mv_n, bg_q, bg_n;
  logic [15:0]     lines_q, lines_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [RW-1:0]   r_q, r_n;
  logic            over_q, over_n;
  logic            lock_c;
  // Button order in the edge registers: {up, down, right, left}
  logic [3:0]      btn_q, btn_qq, press;

  logic [N-1:0]    dn_shift, lf_shift, rt_shift, lower, keep;
  logic            dn_ok, lf_ok, rt_ok, tick, do_down, row_full;
  logic [COLS-1:0] row_bits;
  int unsigned     rbase;

  assign press = btn_q & ~btn_qq;

  always_comb begin
    state_n  = state_q;
    mv_n     = mv_q;
    bg_n     = bg_q;
    lines_n  = lines_q;
    cnt_n    = cnt_q;
    r_n      = r_q;
    over_n   = over_q;
    lock_c   = 1'b0;

    dn_shift = mv_q << COLS;
    lf_shift = mv_q >> 1;
    rt_shift = mv_q << 1;
    dn_ok    = ((mv_q & LASTROW) == '0) && ((dn_shift & bg_q) == '0);
    lf_ok    = ((mv_q & COL0) == '0) && ((lf_shift & bg_q) == '0);
    rt_ok    = ((mv_q & COLL) == '0) && ((rt_shift & bg_q) == '0);
    tick     = (cnt_q == CW'(DROP_TICKS - 1));
    do_down  = tick || (!press[3] && press[2]);

    rbase    = 32'(r_q) * COLS;
    row_bits = COLS'(bg_q >> rbase);
    row_full = &row_bits;
    // Rows above r collapse one row down; rows below r are untouched.
    lower    = ~(ONES << rbase);
    keep     = ONES << (rbase + COLS);

    unique case (state_q)
      S_SPAWN: begin
        mv_n = SPAWN_PIECE;
        if ((SPAWN_PIECE & bg_q) != '0) begin
          state_n = S_OVER;
          over_n  = 1'b1;
        end else begin
          cnt_n   = '0;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        cnt_n = tick ? '0 : cnt_q + CW'(1);
        if (do_down) begin
          if (dn_ok) mv_n = dn_shift;
          else       state_n = S_LOCK;
        end else if (press[3]) begin
          state_n = S_DROP;
        end else if (press[0]) begin
          if (lf_ok) mv_n = lf_shift;
        end else if (press[1]) begin
          if (rt_ok) mv_n = rt_shift;
        end
      end
      S_DROP: begin
        if (dn_ok) mv_n = dn_shift;
        else       state_n = S_LOCK;
      end
      S_LOCK: begin
        bg_n    = bg_q | mv_q;
        mv_n    = '0;
        lock_c  = 1'b1;
        r_n     = RW'(ROWS - 1);
        state_n = S_CLEAR;
      end
      S_CLEAR: begin
        if (row_full) begin
          bg_n = (bg_q & keep) | ((bg_q & lower) << COLS);
          if (lines_q != 16'hFFFF) lines_n = lines_q + 16'd1;
        end else if (r_q == '0) begin
          state_n = S_SPAWN;
        end else begin
          r_n = r_q - RW'(1);
        end
      end
      S_OVER: ;
      default: state_n = S_SPAWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SPAWN;
      mv_q    <= '0;
      bg_q    <= INIT_BG;
      lines_q <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      over_q  <= 1'b0;
      btn_q   <= '0;
      btn_qq  <= '0;
    end else begin
      state_q <= state_n;
      mv_q    <= mv_n;
      bg_q    <= bg_n;
      lines_q <= lines_n;
      cnt_q   <= cnt_n;
      r_q     <= r_n;
      over_q  <= over_n;
      btn_q   <= {up, down, right, left};
      btn_qq  <= btn_q;
    end
  end

  assign moving_squares = mv_q;
  assign background     = bg_q;
  assign lines_cleared  = lines_q;
  assign lock_pulse     = lock_c;
  assign game_over      = over_q;

endmodule

// File: tb/tb_piece_step_ctrl.sv
// Scoreboard bench for piece_step_ctrl: three instances with different start backgrounds,
// expectations queued at stimulus time and compared after the cycle advance.
module tb_piece_step_ctrl;

  localparam int unsigned N = 144;
  localparam logic [N-1:0] SP     = 144'h20070;
  localparam logic [N-1:0] BG_CLR = 144'hFDF << 132;
  localparam logic [N-1:0] BG_OVR = 144'h20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   rst, lf, rt, dn, ub;
  logic [N-1:0] mv [3];
  logic [N-1:0] bg [3];
  logic [15:0]  lc [3];
  logic         lp [3];
  logic         go [3];

  piece_step_ctrl #(.COLS(12), .ROWS(12), .DROP_TICKS(4), .SPAWN_PIECE(SP), .INIT_BG(144'h0)) u_dut (
    .clk(clk), .reset(rst[0]), .left(lf[0]), .right(rt[0]), .down(dn[0]), .up(ub[0]),
    .moving_squares(mv[0]), .background(bg[0]), .lines_cleared(lc[0]),
    .lock_pulse(lp[0]), .game_over(go[0]));

  piece_step_ctrl #(.COLS(12), .ROWS(12), .DROP_TICKS(4), .SPAWN_PIECE(SP), .INIT_BG(BG_CLR)) u_dut_clr (
    .clk(clk), .reset(rst[1]), .left(lf[1]), .right(rt[1]), .down(dn[1]), .up(ub[1]),
    .moving_squares(mv[1]), .background(bg[1]), .lines_cleared(lc[1]),
    .lock_pulse(lp[1]), .game_over(go[1]));

  piece_step_ctrl #(.COLS(12), .ROWS(12), .DROP_TICKS(4), .SPAWN_PIECE(SP), .INIT_BG(BG_OVR)) u_dut_ovr (
    .clk(clk), .reset(rst[2]), .left(lf[2]), .right(rt[2]), .down(dn[2]), .up(ub[2]),
    .moving_squares(mv[2]), .background(bg[2]), .lines_cleared(lc[2]),
    .lock_pulse(lp[2]), .game_over(go[2]));

  typedef struct {
    string        tag;
    int unsigned  dut;
    int unsigned  sig;   // 0 moving, 1 background, 2 lines, 3 lock_pulse, 4 game_over
    logic [N-1:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] observe(input int unsigned d, input int unsigned s);
    case (s)
      0:       return mv[d];
      1:       return bg[d];
      2:       return N'(lc[d]);
      3:       return N'(lp[d]);
      default: return N'(go[d]);
    endcase
  endfunction

  task automatic push(input string tag, input int unsigned d, input int unsigned s, input logic [N-1:0] e);
    exp_t x;
    x.tag = tag; x.dut = d; x.sig = s; x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      check(x.tag, observe(x.dut, x.sig), x.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = '1; lf = '0; rt = '0; dn = '0; ub = '0;
    step(3);
    push("rst_mv", 0, 0, '0);  push("rst_bg", 0, 1, '0);  push("rst_lines", 0, 2, '0);
    push("rst_lock", 0, 3, '0); push("rst_over", 0, 4, '0); push("rst_over_c", 2, 4, '0);
    push("rst_bg_c", 2, 1, BG_OVR);
    drain();

    // Gravity only: spawn, one row per 4 cycles, lock at the floor, respawn
    rst[0] = 1'b0;
    step(1);  push("t1_spawn", 0, 0, SP); drain();
    step(3);  push("t1_hold", 0, 0, SP); drain();
    step(1);  push("t1_row1", 0, 0, SP << 12); drain();
    step(36); push("t1_row10", 0, 0, SP << 120); push("t1_nolock", 0, 3, '0); drain();
    step(3);  push("t1_nolock2", 0, 3, '0); drain();
    step(1);  push("t1_lock", 0, 3, 1); push("t1_lock_mv", 0, 0, SP << 120); drain();
    step(1);  push("t1_bg", 0, 1, SP << 120); push("t1_mv0", 0, 0, '0); push("t1_lock_off", 0, 3, '0); drain();
    step(12); push("t1_clear_mv", 0, 0, '0); drain();
    step(1);  push("t1_respawn", 0, 0, SP); push("t1_bg_keep", 0, 1, SP << 120); drain();

    // Held left moves once; repeated presses stop at col 0 without wrapping
    rst[0] = 1'b1; step(2); rst[0] = 1'b0;
    step(1);
    lf[0] = 1'b1;
    step(2);  push("t2_left1", 0, 0, 144'h10038); drain();
    step(1);  push("t2_norepeat", 0, 0, 144'h10038); drain();
    step(7);  push("t2_held", 0, 0, 144'h10038 << 24); drain();
    lf[0] = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      lf[0] = 1'b1; step(1);
      lf[0] = 1'b0; step(1);
    end
    push("t2_col0", 0, 0, (SP >> 4) << 60); drain();

    // Tick and left pulse in the same cycle: only the down shift
    rst[0] = 1'b1; step(2); rst[0] = 1'b0;
    step(3);
    lf[0] = 1'b1;
    step(2);  push("t6_tick_wins", 0, 0, SP << 12); drain();
    lf[0] = 1'b0;
    step(1);  push("t6_left_dropped", 0, 0, SP << 12); drain();

    // Hard drop
    rst[0] = 1'b1; step(2); rst[0] = 1'b0;
    step(1);
    ub[0] = 1'b1; step(1); ub[0] = 1'b0;
    step(1);  push("t3_enter", 0, 0, SP); drain();
    step(1);  push("t3_drop1", 0, 0, SP << 12); drain();
    step(9);  push("t3_bottom", 0, 0, SP << 120); push("t3_nolock", 0, 3, '0); drain();
    step(1);  push("t3_lock", 0, 3, 1); drain();
    step(1);  push("t3_bg", 0, 1, SP << 120); push("t3_mv0", 0, 0, '0); drain();
    step(12); push("t3_clear_mv", 0, 0, '0); drain();
    step(1);  push("t3_respawn", 0, 0, SP); drain();

    // Line clear, then reset partway through the clear pass
    rst[1] = 1'b0;
    step(1);  push("t4_spawn", 1, 0, SP); push("t4_bg_init", 1, 1, BG_CLR); drain();
    ub[1] = 1'b1; step(1); ub[1] = 1'b0;
    step(11); push("t4_bottom", 1, 0, SP << 120); drain();
    step(1);  push("t4_lock", 1, 3, 1); drain();
    step(1);  push("t4_merged", 1, 1, BG_CLR | (SP << 120)); push("t4_lines0", 1, 2, '0); drain();
    step(1);  push("t4_cleared", 1, 1, 144'h7 << 136); push("t4_lines1", 1, 2, 1); drain();
    step(1);  push("t4_stable", 1, 1, 144'h7 << 136); drain();
    rst[1] = 1'b1;
    step(1);  push("t6_rst_bg", 1, 1, BG_CLR); push("t6_rst_lines", 1, 2, '0); push("t6_rst_mv", 1, 0, '0); drain();

    // Spawn onto an occupied cell: game over, everything frozen
    rst[2] = 1'b0;
    step(1);  push("t5_over", 2, 4, 1); push("t5_mv", 2, 0, SP); drain();
    ub[2] = 1'b1; lf[2] = 1'b1; rt[2] = 1'b1; dn[2] = 1'b1;
    step(3);
    ub[2] = 1'b0; lf[2] = 1'b0; rt[2] = 1'b0; dn[2] = 1'b0;
    step(10);
    push("t5_frozen_mv", 2, 0, SP); push("t5_frozen_bg", 2, 1, BG_OVR);
    push("t5_sticky", 2, 4, 1); push("t5_lines", 2, 2, '0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
